lsu_axil: RTL and testbench

- Parametrised load/store unit for the nano_rv32i core; replaces the fixed word-only LSU.
- Takes one load/store request at a time from the execute stage and runs it as a single AXI4-Lite transaction.
- Adds byte/halfword/word sizes, write strobes, load sign/zero extension, misalignment trapping, independent AW/W handshakes and bus error reporting.
- Sits between the execute/writeback stages and the data-side AXI4-Lite interconnect.

---
 rtl/lsu_axil.sv | 199 +++++++++++++++++++
 tb/tb_lsu_axil.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_axil.sv
// rtl/lsu_axil.sv - AXI4-Lite load/store unit, one transaction at a time
// Byte/half/word accesses with strobes, load extension and misalignment trapping.
module lsu_axil #(
  parameter int ADDR_W      = 32,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_misalign_o,
  output logic [ADDR_W-1:0] m_awaddr_o,
  output logic              m_awvalid_o,
  input  logic              m_awready_i,
  output logic [31:0]       m_wdata_o,
  output logic [3:0]        m_wstrb_o,
  output logic              m_wvalid_o,
  input  logic              m_wready_i,
  input  logic [1:0]        m_bresp_i,
  input  logic              m_bvalid_i,
  output logic              m_bready_o,
  output logic [ADDR_W-1:0] m_araddr_o,
  output logic              m_arvalid_o,
  input  logic              m_arready_i,
  input  logic [31:0]       m_rdata_i,
  input  logic [1:0]        m_rresp_i,
  input  logic              m_rvalid_i,
  output logic              m_rready_o
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;

  state_t      state;
  logic        aw_done;
  logic        w_done;
  logic        unsigned_q;
  logic [1:0]  size_q;
  logic [1:0]  lo_q;

  logic        misalign;
  logic        trap;
  logic [1:0]  lo_eff;
  logic [31:0] wdata_rep;
  logic [3:0]  wstrb_c;
  logic [31:0] lane;
  logic [31:0] load_ext;
  logic        unused_resp_lsb;

  // Only bit 1 of a response distinguishes OKAY/EXOKAY from SLVERR/DECERR.
  assign unused_resp_lsb = m_bresp_i[0] ^ m_rresp_i[0];

  assign req_ready_o = (state == IDLE);

  always_comb begin
    misalign = ((req_size_i == 2'd1) && req_addr_i[0]) ||
               ((req_size_i == 2'd2) && (req_addr_i[1:0] != 2'b00));
    trap     = (req_size_i == 2'd3) || (ALIGN_CHECK && misalign);
    lo_eff   = req_addr_i[1:0];
    if (req_size_i == 2'd1)
      lo_eff[0] = 1'b0;
    else if (req_size_i == 2'd2)
      lo_eff = 2'b00;
    case (req_size_i)
      2'd0: begin
        wdata_rep = {4{req_wdata_i[7:0]}};
        wstrb_c   = 4'b0001 << lo_eff;
      end
      2'd1: begin
        wdata_rep = {2{req_wdata_i[15:0]}};
        wstrb_c   = 4'b0011 << {lo_eff[1], 1'b0};
      end
      default: begin
        wdata_rep = req_wdata_i;
        wstrb_c   = 4'b1111;
      end
    endcase
  end

  always_comb begin
    lane = m_rdata_i >> {lo_q, 3'b000};
    case (size_q)
      2'd0:    load_ext = {{24{~unsigned_q & lane[7]}}, lane[7:0]};
      2'd1:    load_ext = {{16{~unsigned_q & lane[15]}}, lane[15:0]};
      default: load_ext = m_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      unsigned_q     <= 1'b0;
      size_q         <= 2'd0;
      lo_q           <= 2'd0;
      rsp_valid_o    <= 1'b0;
      rsp_rdata_o    <= 32'd0;
      rsp_err_o      <= 1'b0;
      rsp_misalign_o <= 1'b0;
      m_awaddr_o     <= '0;
      m_awvalid_o    <= 1'b0;
      m_wdata_o      <= 32'd0;
      m_wstrb_o      <= 4'd0;
      m_wvalid_o     <= 1'b0;
      m_bready_o     <= 1'b0;
      m_araddr_o     <= '0;
      m_arvalid_o    <= 1'b0;
      m_rready_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            size_q     <= req_size_i;
            unsigned_q <= req_unsigned_i;
            lo_q       <= lo_eff;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            if (trap) begin
              state          <= RESP;
              rsp_valid_o    <= 1'b1;
              rsp_err_o      <= (req_size_i == 2'd3);
              rsp_misalign_o <= 1'b1;
              rsp_rdata_o    <= 32'd0;
            end else if (req_we_i) begin
              m_awaddr_o  <= {req_addr_i[ADDR_W-1:2], 2'b00};
              m_wdata_o   <= wdata_rep;
              m_wstrb_o   <= wstrb_c;
              m_awvalid_o <= 1'b1;
              m_wvalid_o  <= 1'b1;
              state       <= WR;
            end else begin
              m_araddr_o  <= {req_addr_i[ADDR_W-1:2], 2'b00};
              m_arvalid_o <= 1'b1;
              state       <= RD_ADDR;
            end
          end
        end
        WR: begin
          // AW and W retire independently; the flags remember which side is done.
          if (m_awvalid_o && m_awready_i) begin
            m_awvalid_o <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (m_wvalid_o && m_wready_i) begin
            m_wvalid_o <= 1'b0;
            w_done     <= 1'b1;
          end
          if (aw_done && w_done) begin
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            m_bready_o <= 1'b1;
            state      <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_bvalid_i) begin
            m_bready_o     <= 1'b0;
            rsp_valid_o    <= 1'b1;
            rsp_err_o      <= m_bresp_i[1];
            rsp_misalign_o <= 1'b0;
            rsp_rdata_o    <= 32'd0;
            state          <= RESP;
          end
        end
        RD_ADDR: begin
          if (m_arready_i) begin
            m_arvalid_o <= 1'b0;
            m_rready_o  <= 1'b1;
            state       <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_rvalid_i) begin
            m_rready_o     <= 1'b0;
            rsp_valid_o    <= 1'b1;
            rsp_err_o      <= m_rresp_i[1];
            rsp_misalign_o <= 1'b0;
            rsp_rdata_o    <= load_ext;
            state          <= RESP;
          end
        end
        RESP: begin
          rsp_valid_o <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axil.sv
// tb/tb_lsu_axil.sv - scoreboard bench for lsu_axil with a small AXI4-Lite slave
// Responses are queued at issue time and checked by a negedge monitor.
module tb_lsu_axil;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
    logic [7:0]  lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_misalign;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready = 1'b0;
  logic [1:0]  m_bresp = 2'b00;
  logic        m_bvalid = 1'b0;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  logic [1:0]  m_rresp = 2'b00;
  logic        m_rvalid = 1'b0;
  logic        m_rready;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int accept_cyc = 0;

  exp_t        sb[$];
  logic [31:0] exp_awaddr[$];
  logic [35:0] exp_w[$];
  logic [31:0] exp_araddr[$];

  int          aw_wait = 0;
  int          w_wait = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [1:0]  rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'd0;
  bit          b_hold = 1'b0;
  bit          got_aw = 1'b0, got_w = 1'b0, got_ar = 1'b0;
  bit          b_hs = 1'b0, r_hs = 1'b0, saw_w_first = 1'b0;
  bit          p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
  logic [31:0] p_awaddr = 32'd0, p_araddr = 32'd0;
  logic [35:0] p_wbeat = 36'd0;
  int          b_count = 0;
  int          ar_count = 0;

  lsu_axil #(.ADDR_W(32), .ALIGN_CHECK(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .rsp_misalign_o(rsp_misalign),
    .m_awaddr_o(m_awaddr), .m_awvalid_o(m_awvalid), .m_awready_i(m_awready),
    .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb), .m_wvalid_o(m_wvalid), .m_wready_i(m_wready),
    .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready),
    .m_araddr_o(m_araddr), .m_arvalid_o(m_arvalid), .m_arready_i(m_arready),
    .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rvalid_i(m_rvalid), .m_rready_o(m_rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input logic e, input logic m, input logic [7:0] l);
    exp_t x;
    x.rdata = rd;
    x.err   = e;
    x.mis   = m;
    x.lat   = l;
    return x;
  endfunction

  // Response monitor
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_misalign", rsp_misalign, e.mis);
        if (e.lat != 8'hFF) chk("rsp_latency", cyc - accept_cyc, e.lat);
      end
    end
  end

  // AXI4-Lite slave: drives on negedge, predicts the handshakes of the next posedge
  always @(negedge clk) begin
    if (rst) begin
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
      got_aw = 0; got_w = 0; got_ar = 0; b_hs = 0; r_hs = 0;
      p_aw = 0; p_w = 0; p_ar = 0;
    end else begin
      if (p_aw) chk("aw_stable", {m_awvalid, m_awaddr}, {1'b1, p_awaddr});
      if (p_w)  chk("w_stable", {m_wvalid, m_wstrb, m_wdata}, {1'b1, p_wbeat});
      if (p_ar) chk("ar_stable", {m_arvalid, m_araddr}, {1'b1, p_araddr});
      if (m_awvalid && !m_wvalid) saw_w_first = 1;

      if (b_hs) m_bvalid = 0;
      b_hs = m_bvalid && m_bready;
      if (b_hs) b_count++;
      if (got_aw && got_w && !b_hold) begin
        m_bvalid = 1; m_bresp = bresp_cfg; got_aw = 0; got_w = 0;
      end

      m_awready = 0;
      if (m_awvalid) begin
        if (aw_wait > 0) aw_wait--;
        else begin
          m_awready = 1; got_aw = 1;
          if (exp_awaddr.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
          else chk("awaddr", m_awaddr, exp_awaddr.pop_front());
        end
      end
      m_wready = 0;
      if (m_wvalid) begin
        if (w_wait > 0) w_wait--;
        else begin
          m_wready = 1; got_w = 1;
          if (exp_w.size() == 0) chk("w_unexpected", 64'd1, 64'd0);
          else chk("wstrb_wdata", {m_wstrb, m_wdata}, exp_w.pop_front());
        end
      end

      if (r_hs) m_rvalid = 0;
      r_hs = m_rvalid && m_rready;
      if (got_ar) begin
        m_rvalid = 1; m_rdata = rdata_cfg; m_rresp = rresp_cfg; got_ar = 0;
      end
      m_arready = 0;
      if (m_arvalid) begin
        m_arready = 1; got_ar = 1; ar_count++;
        if (exp_araddr.size() == 0) chk("ar_unexpected", 64'd1, 64'd0);
        else chk("araddr", m_araddr, exp_araddr.pop_front());
      end

      p_aw = m_awvalid && !m_awready; p_awaddr = m_awaddr;
      p_w  = m_wvalid && !m_wready;   p_wbeat  = {m_wstrb, m_wdata};
      p_ar = m_arvalid && !m_arready; p_araddr = m_araddr;
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input exp_t e, input bit expect_rsp);
    int n;
    @(negedge clk);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 64'd0, 64'd1);
    accept_cyc = cyc;
    if (expect_rsp) sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 0;
    if (expect_rsp) begin
      n = 0;
      while (sb.size() != 0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (sb.size() != 0) begin
        chk("rsp_timeout", 64'd0, 64'd1);
        sb.delete();
      end
    end
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] ea, input logic [31:0] ewd, input logic [3:0] es,
                       input exp_t e);
    exp_awaddr.push_back(ea);
    exp_w.push_back({es, ewd});
    issue(1'b1, sz, 1'b0, a, wd, e, 1'b1);
  endtask

  task automatic load(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                      input logic [31:0] ea, input logic [31:0] rd, input logic [1:0] rr,
                      input exp_t e);
    rdata_cfg = rd;
    rresp_cfg = rr;
    exp_araddr.push_back(ea);
    issue(1'b0, sz, uns, a, 32'd0, e, 1'b1);
  endtask

  initial begin
    int b0, ar0, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                         rsp_valid, rsp_err, rsp_misalign}, 8'd0);
    chk("reset_data", {m_awaddr, m_araddr}, 64'd0);
    chk("reset_wdata", {m_wstrb, m_wdata, rsp_rdata}, 68'd0);
    rst = 0;

    store(2'd2, 32'h100, 32'hDEADBEEF, 32'h100, 32'hDEADBEEF, 4'b1111, mk(32'd0, 0, 0, 8'd4));
    store(2'd0, 32'h203, 32'h000000A5, 32'h200, 32'hA5A5A5A5, 4'b1000, mk(32'd0, 0, 0, 8'd4));
    store(2'd1, 32'h302, 32'h00001234, 32'h300, 32'h12341234, 4'b1100, mk(32'd0, 0, 0, 8'd4));
    load(2'd0, 1'b0, 32'h102, 32'h100, 32'h00800000, 2'b00, mk(32'hFFFFFF80, 0, 0, 8'hFF));
    load(2'd0, 1'b1, 32'h102, 32'h100, 32'h00800000, 2'b00, mk(32'h00000080, 0, 0, 8'hFF));
    load(2'd1, 1'b0, 32'h102, 32'h100, 32'h80010000, 2'b00, mk(32'hFFFF8001, 0, 0, 8'hFF));
    load(2'd1, 1'b1, 32'h102, 32'h100, 32'h80010000, 2'b00, mk(32'h00008001, 0, 0, 8'hFF));
    load(2'd0, 1'b0, 32'h101, 32'h100, 32'h00007F00, 2'b00, mk(32'h0000007F, 0, 0, 8'hFF));
    load(2'd2, 1'b0, 32'h104, 32'h104, 32'hCAFEF00D, 2'b00, mk(32'hCAFEF00D, 0, 0, 8'hFF));

    // W accepted three cycles ahead of AW
    b0 = b_count;
    saw_w_first = 0;
    aw_wait = 3;
    store(2'd2, 32'h108, 32'h11223344, 32'h108, 32'h11223344, 4'b1111, mk(32'd0, 0, 0, 8'hFF));
    repeat (5) @(negedge clk);
    chk("w_before_aw", saw_w_first, 1'b1);
    chk("b_consumed_once", b_count - b0, 1);

    ar0 = ar_count;
    issue(1'b0, 2'd2, 1'b0, 32'h101, 32'd0, mk(32'd0, 0, 1, 8'd1), 1'b1);
    issue(1'b0, 2'd3, 1'b0, 32'h100, 32'd0, mk(32'd0, 1, 1, 8'd1), 1'b1);
    issue(1'b1, 2'd1, 1'b0, 32'h101, 32'h5555, mk(32'd0, 0, 1, 8'd1), 1'b1);
    repeat (3) @(negedge clk);
    chk("trap_no_ar", ar_count - ar0, 0);

    load(2'd2, 1'b0, 32'h10C, 32'h10C, 32'h00000000, 2'b10, mk(32'd0, 1, 0, 8'hFF));
    bresp_cfg = 2'b11;
    store(2'd2, 32'h110, 32'h0, 32'h110, 32'h0, 4'b1111, mk(32'd0, 1, 0, 8'd4));
    bresp_cfg = 2'b00;

    // Reset while waiting on B
    b_hold = 1;
    exp_awaddr.push_back(32'h120);
    exp_w.push_back({4'b1111, 32'h0F0F0F0F});
    issue(1'b1, 2'd2, 1'b0, 32'h120, 32'h0F0F0F0F, mk(32'd0, 0, 0, 8'hFF), 1'b0);
    n = 0;
    while (!m_bready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wr_resp", m_bready, 1'b1);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_req_ready", req_ready, 1'b1);
    chk("midrst_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid}, 6'd0);
    @(negedge clk);
    rst = 0;
    b_hold = 0;
    exp_awaddr.delete();
    exp_w.delete();

    load(2'd2, 1'b0, 32'h130, 32'h130, 32'h0BADF00D, 2'b00, mk(32'h0BADF00D, 0, 0, 8'hFF));
    repeat (3) @(negedge clk);
    chk("leftover_queues", exp_awaddr.size() + exp_w.size() + exp_araddr.size() + sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
